// File: rtl/time_master_pkg.sv
// time_master_pkg
//   Shared definitions for the master timebase: register map addresses,
//   CTRL / STATUS bit positions and a helper that packs the STATUS word.
package time_master_pkg;

  localparam logic [2:0] ADDR_TIME_NOW = 3'd0;
  localparam logic [2:0] ADDR_TIME_PPS = 3'd1;
  localparam logic [2:0] ADDR_CTRL     = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;

  localparam int CTRL_INV_BIT     = 0;
  localparam int CTRL_EN_BIT      = 1;
  localparam int STATUS_ARMED_BIT = 0;
  localparam int STATUS_SEEN_BIT  = 1;

  function automatic logic [31:0] status_word(input logic pps_seen, input logic armed);
    logic [31:0] word;
    word = '0;
    word[STATUS_SEEN_BIT]  = pps_seen;
    word[STATUS_ARMED_BIT] = armed;
    return word;
  endfunction

endpackage

// File: rtl/time_master_pps.sv
// pps_sync
//   Brings the external PPS into the sys_clk domain and produces a one-cycle
//   pulse per rising edge of (pps ^ invert), gated by enable.
// Ports
//   clk        in  1  sys clock, posedge
//   rst        in  1  asynchronous active-high reset
//   pps        in  1  raw PPS, asynchronous to clk
//   invert     in  1  treat falling PPS edges as the active edge
//   enable     in  1  qualifies the output pulse
//   pps_edge   out 1  one-cycle pulse, SYNC_STAGES+1 cycles after the raw rise
module pps_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic pps,
  input  logic invert,
  input  logic enable,
  output logic pps_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  // fill_q marks when sync_q / prev_q hold genuine post-reset samples, so a
  // PPS held high across reset is not mistaken for a rising edge.
  logic [SYNC_STAGES:0]   fill_q;
  logic                   prev_q;
  logic                   rise_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      fill_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pps ^ invert};
      fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
      prev_q <= sync_q[SYNC_STAGES-1];
      rise_q <= fill_q[SYNC_STAGES] & sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  // Enable is applied at the edge cycle itself, not at detection time.
  assign pps_edge = rise_q & enable;

endmodule

// File: rtl/time_master.sv
// time_master
//   Free-running 32-bit master timebase with immediate load, PPS-armed load,
//   PPS time latch and a small wishbone-style register slave.
// Ports
//   sys_clk_i      in  1   clock, posedge
//   rst_i          in  1   asynchronous active-high reset
//   cyc_i, stb_i   in  1   bus cycle / strobe
//   adr_i          in  3   register address
//   we_i           in  1   write enable
//   dat_i          in  32  write data
//   dat_o          out 32  read data, valid while ack_o=1
//   ack_o          out 1   one-cycle registered acknowledge
//   pps_i          in  1   external PPS, asynchronous
//   master_time_o  out 32  current time
//   pps_int_o      out 1   one-cycle pulse per qualified PPS edge
module time_master
  import time_master_pkg::*;
#(
  parameter int         SYNC_STAGES  = 2,
  parameter logic [1:0] CTRL_DEFAULT = 2'b00
) (
  input  logic        sys_clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic [2:0]  adr_i,
  input  logic        we_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  input  logic        pps_i,
  output logic [31:0] master_time_o,
  output logic        pps_int_o
);

  logic [31:0] pps_time;
  logic [31:0] set_val;
  logic        armed;
  logic        pps_seen;
  logic [1:0]  ctrl;

  logic        access;
  logic        wr_now;
  logic        wr_pps;
  logic        wr_ctrl;
  logic        wr_status;
  logic        pps_edge;
  logic [31:0] rd_data;

  // ack_o blocks the next access, so a held strobe is acked every other cycle.
  assign access    = cyc_i & stb_i & ~ack_o;
  assign wr_now    = access & we_i & (adr_i == ADDR_TIME_NOW);
  assign wr_pps    = access & we_i & (adr_i == ADDR_TIME_PPS);
  assign wr_ctrl   = access & we_i & (adr_i == ADDR_CTRL);
  assign wr_status = access & we_i & (adr_i == ADDR_STATUS);

  pps_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pps_sync (
    .clk      (sys_clk_i),
    .rst      (rst_i),
    .pps      (pps_i),
    .invert   (ctrl[CTRL_INV_BIT]),
    .enable   (ctrl[CTRL_EN_BIT]),
    .pps_edge (pps_edge)
  );

  always_comb begin
    rd_data = '0;
    case (adr_i)
      ADDR_TIME_NOW: rd_data = master_time_o;
      ADDR_TIME_PPS: rd_data = pps_time;
      ADDR_CTRL:     rd_data = {30'b0, ctrl};
      ADDR_STATUS:   rd_data = status_word(pps_seen, armed);
      default:       rd_data = '0;
    endcase
  end

  // Counter: a software load beats an armed PPS load in the same cycle.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      master_time_o <= '0;
    end else if (wr_now) begin
      master_time_o <= dat_i;
    end else if (pps_edge && armed) begin
      master_time_o <= set_val;
    end else begin
      master_time_o <= master_time_o + 32'd1;
    end
  end

  // Arm logic: armed only drops when its load actually took effect.
  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      set_val <= '0;
      armed   <= 1'b0;
    end else if (wr_pps) begin
      set_val <= dat_i;
      armed   <= 1'b1;
    end else if (pps_edge && armed && !wr_now) begin
      armed   <= 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      pps_time  <= '0;
      pps_seen  <= 1'b0;
      pps_int_o <= 1'b0;
    end else begin
      pps_int_o <= pps_edge;
      if (pps_edge) begin
        pps_time <= master_time_o;
      end
      // A new edge outranks a simultaneous software clear.
      if (pps_edge) begin
        pps_seen <= 1'b1;
      end else if (wr_status) begin
        pps_seen <= 1'b0;
      end
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl <= CTRL_DEFAULT;
    end else if (wr_ctrl) begin
      ctrl <= dat_i[1:0];
    end
  end

  always_ff @(posedge sys_clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o <= 1'b0;
      dat_o <= '0;
    end else begin
      ack_o <= access;
      dat_o <= access ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_time_master.sv
module tb_time_master;
  localparam int S = 2;

  logic        sys_clk_i = 1'b0;
  logic        rst_i;
  logic        cyc_i, stb_i, we_i, pps_i;
  logic [2:0]  adr_i;
  logic [31:0] dat_i;
  logic [31:0] dat_o, master_time_o;
  logic        ack_o, pps_int_o;

  always #5 sys_clk_i = ~sys_clk_i;

  time_master #(.SYNC_STAGES(S), .CTRL_DEFAULT(2'b00)) dut (
    .sys_clk_i     (sys_clk_i),
    .rst_i         (rst_i),
    .cyc_i         (cyc_i),
    .stb_i         (stb_i),
    .adr_i         (adr_i),
    .we_i          (we_i),
    .dat_i         (dat_i),
    .dat_o         (dat_o),
    .ack_o         (ack_o),
    .pps_i         (pps_i),
    .master_time_o (master_time_o),
    .pps_int_o     (pps_int_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: register-level view of the timebase.
  logic [31:0] m_time, m_pps_time, m_set, m_dat;
  logic        m_armed, m_seen, m_ack, m_int;
  logic [1:0]  m_ctrl;
  int          hist[$];  // (pps ^ invert) sampled at each post-reset clock edge

  task automatic model_reset();
    m_time = 0; m_pps_time = 0; m_set = 0; m_dat = 0;
    m_armed = 0; m_seen = 0; m_ack = 0; m_int = 0; m_ctrl = 2'b00;
    hist.delete();
  endtask

  task automatic model_step();
    bit          acc, qual, w_now, w_pps, w_ctrl, w_stat;
    int          n;
    logic [31:0] rd;
    acc = cyc_i & stb_i & ~m_ack;
    w_now  = acc && we_i && adr_i == 3'd0;
    w_pps  = acc && we_i && adr_i == 3'd1;
    w_ctrl = acc && we_i && adr_i == 3'd2;
    w_stat = acc && we_i && adr_i == 3'd3;
    hist.push_back(int'(pps_i ^ m_ctrl[0]));
    n = hist.size();
    // Edge in the cycle just ending: synchronized value rose S+1 cycles after sampling.
    qual = (n >= S + 3) && hist[n-2-S] == 1 && hist[n-3-S] == 0 && m_ctrl[1];
    case (adr_i)
      3'd0: rd = m_time;
      3'd1: rd = m_pps_time;
      3'd2: rd = {30'b0, m_ctrl};
      3'd3: rd = {30'b0, m_seen, m_armed};
      default: rd = 0;
    endcase
    m_dat = acc ? rd : 32'd0;
    m_ack = acc;
    m_int = qual;
    if (qual) m_pps_time = m_time;
    if (w_now) m_time = dat_i;
    else if (qual && m_armed) m_time = m_set;
    else m_time = m_time + 1;
    if (w_pps) begin
      m_set = dat_i;
      m_armed = 1;
    end else if (qual && m_armed && !w_now) begin
      m_armed = 0;
    end
    if (qual) m_seen = 1;
    else if (w_stat) m_seen = 0;
    if (w_ctrl) m_ctrl = dat_i[1:0];
  endtask

  task automatic compare_all();
    check("time", master_time_o, m_time);
    check("ack", {31'b0, ack_o}, {31'b0, m_ack});
    check("pps_int", {31'b0, pps_int_o}, {31'b0, m_int});
    if (m_ack) check("dat", dat_o, m_dat);
  endtask

  task automatic tick();
    @(posedge sys_clk_i);
    if (!rst_i) model_step();
    #1;
    compare_all();
  endtask

  task automatic bus_start(input logic [2:0] a, input logic w, input logic [31:0] d);
    cyc_i = 1; stb_i = 1; adr_i = a; we_i = w; dat_i = d;
  endtask

  task automatic bus_idle();
    cyc_i = 0; stb_i = 0; we_i = 0; adr_i = 0; dat_i = 0;
  endtask

  task automatic access(input logic [2:0] a, input logic w, input logic [31:0] d);
    bus_start(a, w, d);
    tick();
    bus_idle();
    tick();
  endtask

  task automatic read_expect(input logic [2:0] a, input logic [31:0] exp, input string tag);
    bus_start(a, 0, 0);
    tick();
    check(tag, dat_o, exp);
    bus_idle();
    tick();
  endtask

  initial begin
    logic [31:0] pre;
    rst_i = 1; pps_i = 0;
    bus_idle();
    model_reset();
    repeat (2) @(posedge sys_clk_i);
    #1;
    check("rst_time", master_time_o, 0);
    check("rst_ack", {31'b0, ack_o}, 0);
    check("rst_dat", dat_o, 0);
    check("rst_int", {31'b0, pps_int_o}, 0);
    rst_i = 0;

    // 1: free run from reset, then wrap
    for (int i = 0; i < 4; i++) begin
      tick();
      check("run_from_rst", master_time_o, i + 1);
    end
    bus_start(0, 1, 32'hFFFF_FFFE);
    tick();
    check("preload", master_time_o, 32'hFFFF_FFFE);
    bus_idle();
    tick();
    check("wrap_ff", master_time_o, 32'hFFFF_FFFF);
    tick();
    check("wrap_0", master_time_o, 0);
    tick();
    check("wrap_1", master_time_o, 1);

    // 2: immediate load and one-cycle ack
    bus_start(0, 1, 32'h1000);
    tick();
    check("load_1000", master_time_o, 32'h1000);
    check("ack_hi", {31'b0, ack_o}, 1);
    bus_idle();
    tick();
    check("ack_lo", {31'b0, ack_o}, 0);
    check("load_1001", master_time_o, 32'h1001);
    read_expect(0, m_time, "rd_now");

    // 3: armed PPS load
    access(2, 1, 32'h2);
    access(1, 1, 32'h5000);
    read_expect(3, 32'h1, "status_armed");
    pps_i = 1;
    for (int i = 0; i < S + 2; i++) begin
      pre = m_time;
      tick();
    end
    check("pps_load", master_time_o, 32'h5000);
    check("pps_int_hi", {31'b0, pps_int_o}, 1);
    tick();
    check("pps_int_lo", {31'b0, pps_int_o}, 0);
    read_expect(1, pre, "pps_time");
    read_expect(3, 32'h2, "status_seen");

    // 4: TIME_NOW write coincides with armed edge
    access(1, 1, 32'h7000);
    pps_i = 0;
    repeat (S + 4) tick();
    pps_i = 1;
    repeat (S + 1) tick();
    bus_start(0, 1, 32'h20);
    tick();
    check("now_wins", master_time_o, 32'h20);
    check("now_wins_int", {31'b0, pps_int_o}, 1);
    bus_idle();
    tick();
    read_expect(3, 32'h3, "still_armed");
    access(3, 1, 32'hFFFF_FFFF);
    read_expect(3, 32'h1, "seen_clr");
    pps_i = 0;
    repeat (S + 4) tick();
    pps_i = 1;
    repeat (S + 2) tick();
    check("second_load", master_time_o, 32'h7000);

    // 5: disabled PPS, then inverted polarity
    access(2, 1, 32'h0);
    for (int i = 0; i < 40; i++) begin
      if (i % 3 == 0) pps_i = ~pps_i;
      tick();
      check("dis_no_int", {31'b0, pps_int_o}, 0);
    end
    pps_i = 1;
    repeat (6) tick();
    access(2, 1, 32'h3);
    repeat (6) tick();
    pps_i = 0;
    repeat (S + 2) tick();
    check("inv_int", {31'b0, pps_int_o}, 1);

    // 6: asynchronous reset while armed, PPS held high across it
    access(1, 1, 32'hABCD);
    pps_i = 1;
    repeat (5) tick();
    @(posedge sys_clk_i);
    model_step();
    #1;
    compare_all();
    #2 rst_i = 1;
    #1;
    model_reset();
    check("arst_time", master_time_o, 0);
    check("arst_ack", {31'b0, ack_o}, 0);
    check("arst_dat", dat_o, 0);
    check("arst_int", {31'b0, pps_int_o}, 0);
    tick();
    tick();
    rst_i = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("post_rst_run", master_time_o, i + 1);
    end
    access(2, 1, 32'h2);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("held_high_no_int", {31'b0, pps_int_o}, 0);
    end
    read_expect(3, 32'h0, "post_rst_status");
    pps_i = 0;
    repeat (S + 4) tick();
    pps_i = 1;
    repeat (S + 2) tick();
    check("post_rst_int", {31'b0, pps_int_o}, 1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) pps_i = ~pps_i;
      if ($urandom_range(0, 2) == 0) begin
        cyc_i = 1;
        stb_i = 1;
        adr_i = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
        we_i  = 1'($urandom_range(0, 1));
        dat_i = (adr_i == 3'd2) ? 32'($urandom_range(0, 3)) : $urandom;
      end else begin
        bus_idle();
      end
      tick();
    end
    bus_idle();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
